counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the bit width of the shared counter and of the run lengths.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, an asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 2, per-requester run request, where bit i belongs to requester i.
REQ-005 The block SHALL have port len0, input, WIDTH, the requested terminal count for requester 0, sampled at grant.
REQ-006 The block SHALL have port len1, input, WIDTH, the requested terminal count for requester 1, sampled at grant.
REQ-007 The block SHALL have port abort, input, 1, which cancels the current run.
REQ-008 The block SHALL have port gnt, output, 2, a one-hot grant that is high for the owner for the whole run.
REQ-009 The block SHALL have port value, output, WIDTH, the shared counter value.
REQ-010 The block SHALL have port busy, output, 1, which is high in RUN or DONE.
REQ-011 The block SHALL have port done, output, 2, a one-cycle completion pulse for the owner.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, on an edge where req is nonzero, the block SHALL enter RUN, set gnt to the winner, latch the winner's len into len_q and clear value to 0.
REQ-014 Arbitration SHALL be round-robin: with both req bits high, the requester not granted last wins; with one bit high, that requester wins.
REQ-015 In RUN without abort, value SHALL increment by 1 per edge while value != len_q.
REQ-016 In RUN, when value == len_q, the next edge SHALL enter DONE, pulse done[owner] for 1 cycle, and hold value and gnt.
REQ-017 A run SHALL therefore present values 0..L; done SHALL rise L+1 edges after the grant edge.
REQ-018 With len = 0, done SHALL rise on the edge after the grant.
REQ-019 In DONE, the next edge SHALL clear gnt and done, record the owner as last-granted and return to IDLE; value SHALL hold its final count.
REQ-020 A new grant SHALL NOT occur in DONE; the earliest re-grant is the edge after the return to IDLE, giving a minimum 1-cycle IDLE gap.
REQ-021 abort in RUN SHALL make the next edge clear gnt, return to IDLE, hold value, produce no done, and update last-granted to the owner.
REQ-022 abort SHALL have no effect in IDLE or DONE.
REQ-023 abort and value == len_q on the same edge SHALL resolve to abort.
REQ-024 After grant, changes to req, len0 and len1 SHALL NOT affect the run in progress.
REQ-025 Counter arithmetic SHALL be unsigned modulo 2^WIDTH, and terminal detection SHALL prevent any wrap (len = 255 ends at 255).
REQ-026 gnt SHALL never have more than one bit set, and done SHALL be nonzero only in DONE.

Reset
REQ-027 Asserting reset_n low SHALL immediately, without a clock, force IDLE, gnt=0, done=0, busy=0, value=0, len_q=0 and last-granted = requester 1, so requester 0 wins the first contention.
REQ-028 Reset mid-run SHALL abandon the run with no done pulse.
REQ-029 Operation SHALL resume on the first rising edge after reset_n returns high.

Configuration
REQ-030 When macro COUNTER_CTRL_PRIO_EN is defined, arbitration SHALL be fixed priority: requester 0 always wins contention, and last-granted is unused.
REQ-031 When COUNTER_CTRL_PRIO_EN is undefined, arbitration SHALL be the round-robin of REQ-014.

Verification
REQ-032 The bench SHALL check a single run: req=01, len0=5 -> gnt=01, value 0,1,2,3,4,5, then done=01 for 1 cycle, then gnt=00 and value holds 5.
REQ-033 The bench SHALL check contention: req=11 held with len0=2, len1=3 -> grants alternate 01,10,01, with each done pulse matching its owner (round-robin build).
REQ-034 The bench SHALL check zero length: req=10, len1=0 -> done=10 exactly one edge after the grant edge, with value=0.
REQ-035 The bench SHALL check abort: req=01, len0=20, abort pulsed when value=7 -> gnt=00 next edge, value holds 7, no done, and a subsequent req=11 grants requester 1.
REQ-036 The bench SHALL check async reset: reset_n pulled low mid-run at value=9 -> value=0, gnt=00 and busy=0 before the next clk edge; after release, req=11 grants requester 0.
REQ-037 The bench SHALL check the priority build: with COUNTER_CTRL_PRIO_EN defined and req=11 held -> requester 0 is granted on every run.

Source files
------------

// File: rtl/counter_ctrl.sv
// Two-requester run controller sharing one up-counter: grant, count 0..len, pulse done, release.
// Define COUNTER_CTRL_PRIO_EN for fixed priority (requester 0 wins); default build is round-robin.
module counter_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] len0,
   input  logic [WIDTH-1:0] len1,
   input  logic             abort,
   output logic [1:0]       gnt,
   output logic [WIDTH-1:0] value,
   output logic             busy,
   output logic [1:0]       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       done_q, done_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic             win;

`ifdef COUNTER_CTRL_PRIO_EN
   always_comb begin
      win = ~req[0];
   end
`else
   // last_q holds the index of the requester that owned the previous run
   logic last_q, last_d;

   always_comb begin
      if (req == 2'b11) begin
         win = ~last_q;
      end else begin
         win = ~req[0];
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      done_d  = 2'b00;
      value_d = value_q;
      len_d   = len_q;
`ifndef COUNTER_CTRL_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               state_d = RUN;
               gnt_d   = win ? 2'b10 : 2'b01;
               len_d   = win ? len1 : len0;
               value_d = '0;
            end
         end
         RUN: begin
            // abort outranks terminal detection on the same edge
            if (abort) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
`ifndef COUNTER_CTRL_PRIO_EN
               last_d  = gnt_q[1];
`endif
            end else if (value_q == len_q) begin
               state_d = DONE;
               done_d  = gnt_q;
            end else begin
               value_d = value_q + ONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
`ifndef COUNTER_CTRL_PRIO_EN
            last_d  = gnt_q[1];
`endif
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         value_q <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         value_q <= value_d;
         len_q   <= len_d;
      end
   end

`ifndef COUNTER_CTRL_PRIO_EN
   // Reset to requester 1 so requester 0 wins the first contention
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign value = value_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random traffic against a run-level model.
module tb_counter_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [1:0]       req;
   logic [WIDTH-1:0] len0, len1;
   logic             abort;
   logic [1:0]       gnt;
   logic [WIDTH-1:0] value;
   logic             busy;
   logic [1:0]       done;

   int n_checks = 0;
   int n_errors = 0;

   counter_ctrl #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .len0    (len0),
      .len1    (len1),
      .abort   (abort),
      .gnt     (gnt),
      .value   (value),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Run-level model: m_k counts edges since the grant; k == len+1 is the completion cycle.
   bit m_act;
   int m_owner, m_len, m_k, m_last, m_val;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int pick(input logic [1:0] r);
`ifdef COUNTER_CTRL_PRIO_EN
      return r[0] ? 0 : 1;
`else
      if (r == 2'b11) return 1 - m_last;
      return r[0] ? 0 : 1;
`endif
   endfunction

   task automatic model_reset();
      m_act = 0; m_owner = 0; m_len = 0; m_k = 0; m_last = 1; m_val = 0;
   endtask

   task automatic model_step(input logic [1:0] r, input int l0, input int l1, input logic ab);
      if (!m_act) begin
         if (r != 2'b00) begin
            m_owner = pick(r);
            m_len   = (m_owner == 1) ? l1 : l0;
            m_k     = 0;
            m_act   = 1;
         end
      end else if (m_k <= m_len) begin
         if (ab) begin
            m_act = 0; m_last = m_owner; m_val = m_k;
         end else begin
            m_k++;
         end
      end else begin
         m_act = 0; m_last = m_owner; m_val = m_len;
      end
   endtask

   task automatic check_all();
      logic [1:0] eg;
      eg = (m_owner == 1) ? 2'b10 : 2'b01;
      if (m_act) begin
         check_eq("gnt",   gnt,   eg);
         check_eq("busy",  busy,  1);
         check_eq("value", value, (m_k > m_len) ? m_len : m_k);
         check_eq("done",  done,  (m_k == m_len + 1) ? eg : 2'b00);
      end else begin
         check_eq("gnt",   gnt,   0);
         check_eq("busy",  busy,  0);
         check_eq("value", value, m_val);
         check_eq("done",  done,  0);
      end
   endtask

   // Drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
   task automatic tick(input logic [1:0] r, input int l0, input int l1, input logic ab);
      req = r; len0 = l0[WIDTH-1:0]; len1 = l1[WIDTH-1:0]; abort = ab;
      @(posedge clk);
      model_step(r, l0, l1, ab);
      @(negedge clk);
      check_all();
   endtask

   logic [1:0] exp_g [3];
   int n;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef COUNTER_CTRL_PRIO_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
`endif
      reset_n = 1'b0; req = 2'b00; len0 = '0; len1 = '0; abort = 1'b0;
      model_reset();
      #1;
      check_eq("rst_gnt", gnt, 0);
      check_eq("rst_value", value, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Contention with req held at 11
      for (int r = 0; r < 3; r++) begin
         n = 0;
         while (gnt == 2'b00 && n < 5) begin tick(2'b11, 2, 3, 0); n++; end
         check_eq("cont_gnt", gnt, exp_g[r]);
         n = 0;
         while (gnt != 2'b00 && n < 10) begin tick(2'b11, 2, 3, 0); n++; end
         check_eq("cont_release", gnt, 0);
      end

      // Single run, len0 = 5
      tick(2'b01, 5, 0, 0);
      check_eq("single_gnt", gnt, 2'b01);
      check_eq("single_v0", value, 0);
      for (int v = 1; v <= 5; v++) begin
         tick(2'b00, 0, 0, 0);
         check_eq("single_val", value, v);
      end
      tick(2'b00, 0, 0, 0);
      check_eq("single_done", done, 2'b01);
      tick(2'b00, 0, 0, 0);
      check_eq("single_gnt_off", gnt, 2'b00);
      check_eq("single_hold", value, 5);
      check_eq("single_done_off", done, 2'b00);

      // Zero length on requester 1
      tick(2'b10, 9, 0, 0);
      check_eq("zero_gnt", gnt, 2'b10);
      check_eq("zero_done_early", done, 2'b00);
      tick(2'b00, 0, 0, 0);
      check_eq("zero_done", done, 2'b10);
      check_eq("zero_value", value, 0);
      tick(2'b00, 0, 0, 0);

      // Full-range run: ends at 255 without wrapping
      tick(2'b01, 255, 0, 0);
      n = 0;
      while (done == 2'b00 && n < 300) begin tick(2'($urandom), $urandom_range(0, 255), $urandom_range(0, 255), 0); n++; end
      check_eq("len255_latency", n, 256);
      check_eq("len255_value", value, 255);
      tick(2'b00, 0, 0, 0);

      // Abort at value 7
      tick(2'b01, 20, 0, 0);
      n = 0;
      while (value != 7 && n < 30) begin tick(2'b00, 0, 0, 0); n++; end
      check_eq("abort_reach", value, 7);
      tick(2'b00, 0, 0, 1);
      check_eq("abort_gnt", gnt, 2'b00);
      check_eq("abort_value", value, 7);
      check_eq("abort_done", done, 2'b00);
      tick(2'b11, 4, 4, 0);
`ifdef COUNTER_CTRL_PRIO_EN
      check_eq("abort_regrant", gnt, 2'b01);
`else
      check_eq("abort_regrant", gnt, 2'b10);
`endif
      n = 0;
      while (gnt != 2'b00 && n < 10) begin tick(2'b00, 0, 0, n == 2); n++; end
      check_eq("abort_idle", gnt, 0);

      // Asynchronous reset mid-run at value 9
      tick(2'b10, 0, 30, 0);
      n = 0;
      while (value != 9 && n < 40) begin tick(2'b00, 0, 0, 0); n++; end
      check_eq("rst_reach", value, 9);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_eq("arst_value", value, 0);
      check_eq("arst_gnt", gnt, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(2'b11, 1, 1, 0);
      check_eq("rst_regrant", gnt, 2'b01);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         tick(2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
